conv_deinterleaver: RTL and testbench



---
 rtl/deint_pkg.sv | 25 ++
 rtl/deint_ram.sv | 22 ++
 rtl/conv_deinterleaver.sv | 85 ++++++++
 tb/tb_conv_deinterleaver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/deint_pkg.sv
// rtl/deint_pkg.sv - geometry constants and branch placement helpers for the Forney de-interleaver
package deint_pkg;

   localparam int I      = 12;
   localparam int M      = 17;
   localparam int W      = 8;
   localparam int D      = M * I * (I - 1) / 2;
   localparam int F      = (I - 1) * M * I;
   localparam int PTR_W  = $clog2((I - 1) * M);
   localparam int ADDR_W = $clog2(D);
   localparam int CNT_W  = 12;
   localparam int BSEL_W = $clog2(I);

   function automatic int branch_len(input int j);
      return (I - 1 - j) * M;
   endfunction

   function automatic int branch_base(input int j);
      int b;
      b = 0;
      for (int k = 0; k < j; k++) b += branch_len(k);
      return b;
   endfunction

endpackage

// File: rtl/deint_ram.sv
// rtl/deint_ram.sv - single-port read-first branch storage with registered read data
module deint_ram
   import deint_pkg::*;
(
   input  logic              clk,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [W-1:0]      wdata,
   output logic [W-1:0]      rdata
);

   logic [W-1:0] mem [D];

   // Read and write share the enable: every RAM access is a read-first replace.
   always_ff @(posedge clk) begin
      if (en) begin
         rdata     <= mem[addr];
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/conv_deinterleaver.sv
// rtl/conv_deinterleaver.sv - I=12, M=17 convolutional de-interleaver, one RAM with per-branch pointers
// Optional forced resync to branch 0 on sync_in: define DEINT_SYNC_EN.
module conv_deinterleaver
   import deint_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] data_in,
   input  logic         in_valid,
   input  logic         sync_in,
   output logic [W-1:0] data_out,
   output logic         out_valid,
   output logic         out_primed
);

   logic [BSEL_W-1:0] bsel;
   logic [BSEL_W-1:0] branch;
   logic [PTR_W-1:0]  ptr [I];
   logic [PTR_W-1:0]  ptr_cur;
   logic [ADDR_W-1:0] base_rom [I];
   logic [PTR_W-1:0]  last_rom [I];
   logic [ADDR_W-1:0] ram_addr;
   logic [W-1:0]      ram_rdata;
   logic [W-1:0]      byp_q;
   logic [CNT_W-1:0]  fill;
   logic              ram_en;
   logic              bypass;
   logic              sel_byp_q;
   logic              sync_force;

   for (genvar g = 0; g < I; g++) begin : g_rom
      assign base_rom[g] = ADDR_W'(branch_base(g));
      assign last_rom[g] = (g == I - 1) ? '0 : PTR_W'(branch_len(g) - 1);
   end

`ifdef DEINT_SYNC_EN
   assign sync_force = in_valid & sync_in;
`else
   logic unused_sync;
   assign unused_sync = sync_in;
   assign sync_force  = 1'b0;
`endif

   always_comb begin
      branch   = sync_force ? '0 : bsel;
      bypass   = (branch == BSEL_W'(I - 1));
      ptr_cur  = ptr[branch];
      ram_addr = base_rom[branch] + ADDR_W'(ptr_cur);
      ram_en   = in_valid & ~bypass;
   end

   deint_ram u_ram (
      .clk   (clk),
      .en    (ram_en),
      .addr  (ram_addr),
      .wdata (data_in),
      .rdata (ram_rdata)
   );

   // Bypass path is selected out of reset so data_out reads the cleared bypass register.
   always_ff @(posedge clk) begin
      if (reset) begin
         bsel       <= '0;
         fill       <= '0;
         out_valid  <= 1'b0;
         out_primed <= 1'b0;
         byp_q      <= '0;
         sel_byp_q  <= 1'b1;
         for (int k = 0; k < I; k++) ptr[k] <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            bsel       <= bypass ? '0 : branch + 1'b1;
            sel_byp_q  <= bypass;
            out_primed <= (fill == CNT_W'(F));
            if (fill != CNT_W'(F)) fill <= fill + 1'b1;
            if (bypass) byp_q <= data_in;
            else        ptr[branch] <= (ptr_cur == last_rom[branch]) ? '0 : ptr_cur + 1'b1;
         end
      end
   end

   assign data_out = sel_byp_q ? byp_q : ram_rdata;

endmodule

// File: tb/tb_conv_deinterleaver.sv
// tb/tb_conv_deinterleaver.sv - directed bench: reference interleaver feeding the de-interleaver
module tb_conv_deinterleaver;
   import deint_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] data_in;
   logic         in_valid;
   logic         sync_in;
   logic [W-1:0] data_out;
   logic         out_valid;
   logic         out_primed;

   int checks = 0;
   int errors = 0;

   logic [7:0] il_mem [12][187];
   int         il_ptr [12];

   conv_deinterleaver dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .in_valid   (in_valid),
      .sync_in    (sync_in),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .out_primed (out_primed)
   );

   always #5 clk = ~clk;

   // Transmit interleaver: branch j delays by j*17 visits to that branch.
   task automatic il_step(input logic [7:0] x, input int j, output logic [7:0] y);
      if (j == 0) begin
         y = x;
      end else begin
         y = il_mem[j][il_ptr[j]];
         il_mem[j][il_ptr[j]] = x;
         il_ptr[j] = (il_ptr[j] + 1) % (j * 17);
      end
   endtask

   task automatic il_clear();
      for (int j = 0; j < 12; j++) begin
         il_ptr[j] = 0;
         for (int k = 0; k < 187; k++) il_mem[j][k] = 8'h00;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; sync_in = 1'b0; data_in = '0;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(3);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks += 4;
         if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
         if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
         if (out_primed !== 1'b0) begin errors++; $display("FAIL reset_out_primed got=%b exp=0", out_primed); end
         if (dut.bsel !== 4'd0) begin errors++; $display("FAIL reset_bsel got=%0d exp=0", dut.bsel); end
      end
   endtask

   task automatic test_bypass();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); in_valid = 1'b1; data_in = 8'(i);
      end
      @(posedge clk); #1;
      checks += 3;
      if (data_out !== 8'h0B) begin errors++; $display("FAIL bypass_data got=%h exp=0b", data_out); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got=%b exp=1", out_valid); end
      if (out_primed !== 1'b0) begin errors++; $display("FAIL bypass_primed got=%b exp=0", out_primed); end
      @(negedge clk); in_valid = 1'b0;
   endtask

   // Streams n mod 256 through the interleaver model into the DUT, from a fresh reset.
   task automatic test_stream(input int count, input bit gap, input string tag);
      int n, cyc, ov_cnt;
      logic v;
      logic [7:0] d, last;
      n = 0; cyc = 0; ov_cnt = 0; last = data_out;
      while (n < count && cyc < count * 4 + 100) begin
         @(negedge clk);
         v = gap ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid = v;
         if (v) begin
            il_step(8'(n), n % 12, d);
            data_in = d;
         end
         @(posedge clk); #1;
         cyc++;
         if (out_valid === 1'b1) ov_cnt++;
         if (v) begin
            checks += 2;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid n=%0d got=%b exp=1", tag, n, out_valid); end
            if (out_primed !== (n >= 2244)) begin
               errors++; $display("FAIL %s_primed n=%0d got=%b exp=%b", tag, n, out_primed, (n >= 2244));
            end
            if (n >= 2244) begin
               checks++;
               if (data_out !== 8'(n - 2244)) begin
                  errors++; $display("FAIL %s_data n=%0d got=%h exp=%h", tag, n, data_out, 8'(n - 2244));
               end
            end
            n++;
         end else begin
            checks += 2;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_idle_valid got=%b exp=0", tag, out_valid); end
            if (data_out !== last) begin errors++; $display("FAIL %s_hold got=%h exp=%h", tag, data_out, last); end
         end
         last = data_out;
      end
      @(negedge clk); in_valid = 1'b0;
      checks += 2;
      if (n != count) begin errors++; $display("FAIL %s_timeout accepted=%0d exp=%0d", tag, n, count); end
      if (ov_cnt != n) begin errors++; $display("FAIL %s_valid_count got=%0d exp=%0d", tag, ov_cnt, n); end
   endtask

   task automatic test_resync();
      do_reset(2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); in_valid = 1'b1; data_in = 8'(8'h10 + i);
      end
      @(negedge clk); in_valid = 1'b0; sync_in = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dut.bsel !== 4'd5) begin errors++; $display("FAIL resync_pre_bsel got=%0d exp=5", dut.bsel); end
      @(negedge clk); in_valid = 1'b1; sync_in = 1'b1; data_in = 8'hA5;
      @(posedge clk); #1;
      checks += 3;
`ifdef DEINT_SYNC_EN
      if (dut.bsel !== 4'd1) begin errors++; $display("FAIL resync_bsel got=%0d exp=1", dut.bsel); end
      if (dut.ptr[0] !== 8'd2) begin errors++; $display("FAIL resync_ptr0 got=%0d exp=2", dut.ptr[0]); end
      if (dut.ptr[5] !== 8'd0) begin errors++; $display("FAIL resync_ptr5 got=%0d exp=0", dut.ptr[5]); end
`else
      if (dut.bsel !== 4'd6) begin errors++; $display("FAIL resync_bsel got=%0d exp=6", dut.bsel); end
      if (dut.ptr[0] !== 8'd1) begin errors++; $display("FAIL resync_ptr0 got=%0d exp=1", dut.ptr[0]); end
      if (dut.ptr[5] !== 8'd1) begin errors++; $display("FAIL resync_ptr5 got=%0d exp=1", dut.ptr[5]); end
`endif
      @(negedge clk); sync_in = 1'b0; data_in = 8'h5A;
      @(posedge clk); #1;
      checks++;
`ifdef DEINT_SYNC_EN
      if (dut.bsel !== 4'd2) begin errors++; $display("FAIL resync_next_bsel got=%0d exp=2", dut.bsel); end
`else
      if (dut.bsel !== 4'd7) begin errors++; $display("FAIL resync_next_bsel got=%0d exp=7", dut.bsel); end
`endif
      @(negedge clk); in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset(2);
      il_clear();
      test_stream(3000, 1'b0, "mid_pre");
      @(posedge clk); #1;
      checks++;
      if (out_primed !== 1'b1) begin errors++; $display("FAIL mid_primed_before got=%b exp=1", out_primed); end
      do_reset(2);
      #1;
      checks += 4;
      if (out_primed !== 1'b0) begin errors++; $display("FAIL mid_primed_after got=%b exp=0", out_primed); end
      if (dut.bsel !== 4'd0) begin errors++; $display("FAIL mid_bsel got=%0d exp=0", dut.bsel); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
      if (data_out !== 8'h00) begin errors++; $display("FAIL mid_data got=%h exp=00", data_out); end
      il_clear();
      test_stream(2400, 1'b0, "mid_refill");
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; sync_in = 1'b0; data_in = '0;
      test_reset();
      test_bypass();
      do_reset(2);
      il_clear();
      test_stream(6000, 1'b0, "round_trip");
      do_reset(2);
      il_clear();
      test_stream(6000, 1'b1, "gapped");
      test_resync();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
